// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch defines (ADDR_WIDTH, INST_WIDTH, IMEMORY_SIZE, NOP_INST, HALT_INST)
// and the IF/ID payload type used by fetch_unit and if_id_register.
`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define ADDR_WIDTH 8
`define INST_WIDTH 32
`define IMEMORY_SIZE 16
`define NOP_INST 32'h0000_0013
`define HALT_INST 32'h0000_0073
`endif

package fetch_unit_pkg;
    typedef struct packed {
        logic [`INST_WIDTH-1:0] inst;
        logic [`ADDR_WIDTH-1:0] pc;
        logic                   valid;
    } if_id_t;
endpackage

// File: rtl/fetch_unit_if_id.sv
// if_id_register: IF/ID pipeline register; squash beats hold beats load.
module if_id_register
    import fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   squash,
    input  logic                   hold,
    input  logic [`INST_WIDTH-1:0] instruction,
    input  logic [`ADDR_WIDTH-1:0] pc,
    output if_id_t                 if_id
);
    if_id_t if_id_d, if_id_q;

    always_comb begin
        if_id_d = if_id_q;
        if (squash)
            if_id_d = '{inst: `NOP_INST, pc: pc, valid: 1'b0};
        else if (load && !hold)
            if_id_d = '{inst: instruction, pc: pc, valid: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            if_id_q <= '{inst: `NOP_INST, pc: '0, valid: 1'b0};
        else
            if_id_q <= if_id_d;
    end

    assign if_id = if_id_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, RUN/HALT FSM and IF/ID staging for a zero-latency instruction memory.
// Define FETCH_HALT_DETECT_EN to stop fetch when HALT_INST is captured.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [`ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [`ADDR_WIDTH-1:0] branch_target,
    input  logic [`INST_WIDTH-1:0] instruction,
    output logic [`ADDR_WIDTH-1:0] pc,
    output logic [`INST_WIDTH-1:0] if_id_instruction,
    output logic [`ADDR_WIDTH-1:0] if_id_pc,
    output logic                   if_id_valid,
    output logic                   halted
);
    typedef enum logic {RUN, HALT} state_e;

    state_e                 state_q, state_d;
    logic [`ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic                   load, squash, hold;
    if_id_t                 if_id;

    assign pc_inc = (32'(pc_q) == `IMEMORY_SIZE - 1) ? '0 : pc_q + 1'b1;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        load    = 1'b0;
        squash  = 1'b0;
        hold    = 1'b0;
        if (branch_taken) begin
            pc_d    = (32'(branch_target) >= `IMEMORY_SIZE) ? '0 : branch_target;
            squash  = 1'b1;
            state_d = RUN;
        end else if (state_q == HALT) begin
            squash = 1'b1;
        end else if (flush) begin
            squash = 1'b1;
            pc_d   = stall ? pc_q : pc_inc;
        end else if (stall) begin
            hold = 1'b1;
        end else begin
            load = 1'b1;
            pc_d = pc_inc;
`ifdef FETCH_HALT_DETECT_EN
            // halt word still enters IF/ID; pc parks on its address
            if (instruction == `HALT_INST) begin
                pc_d    = pc_q;
                state_d = HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_register u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .squash      (squash),
        .hold        (hold),
        .instruction (instruction),
        .pc          (pc_q),
        .if_id       (if_id)
    );

    assign pc                = pc_q;
    assign if_id_instruction = if_id.inst;
    assign if_id_pc          = if_id.pc;
    assign if_id_valid       = if_id.valid;
`ifdef FETCH_HALT_DETECT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed steps with a queue of expected post-edge states, checked by assertions.
module tb_fetch_unit;
    typedef struct {
        logic [`ADDR_WIDTH-1:0] pc;
        logic [`INST_WIDTH-1:0] inst;
        logic [`ADDR_WIDTH-1:0] ipc;
        logic                   valid;
        logic                   halted;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset, stall, flush, branch_taken;
    logic [`ADDR_WIDTH-1:0] branch_target;
    logic [`INST_WIDTH-1:0] instruction;
    logic [`ADDR_WIDTH-1:0] pc, if_id_pc;
    logic [`INST_WIDTH-1:0] if_id_instruction;
    logic                   if_id_valid, halted;
    logic [`INST_WIDTH-1:0] imem [`IMEMORY_SIZE];
    exp_t                   sb [$];
    int                     errors = 0;
    int                     checks = 0;

    localparam logic [`INST_WIDTH-1:0] NOP  = `NOP_INST;
    localparam logic [`INST_WIDTH-1:0] HLT  = `HALT_INST;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    always #5 clk = ~clk;

    assign instruction = (32'(pc) < `IMEMORY_SIZE) ? imem[pc[3:0]] : NOP;

    fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .instruction       (instruction),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
    );

    function automatic logic [`INST_WIDTH-1:0] iw(input int a);
        return (a == 6) ? HLT : 32'hA000_0000 + 32'(a);
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic b, input int t);
        reset = r; stall = s; flush = f; branch_taken = b; branch_target = `ADDR_WIDTH'(t);
    endtask

    task automatic expect_st(input int p, input logic [`INST_WIDTH-1:0] i, input int ip, input logic v, input logic h);
        sb.push_back('{pc: `ADDR_WIDTH'(p), inst: i, ipc: `ADDR_WIDTH'(ip), valid: v, halted: h});
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 5;
        assert (pc === e.pc) else begin errors++; $error("FAIL %s pc got %0d want %0d", tag, pc, e.pc); end
        assert (if_id_instruction === e.inst) else begin errors++; $error("FAIL %s inst got %h want %h", tag, if_id_instruction, e.inst); end
        assert (if_id_pc === e.ipc) else begin errors++; $error("FAIL %s if_id_pc got %0d want %0d", tag, if_id_pc, e.ipc); end
        assert (if_id_valid === e.valid) else begin errors++; $error("FAIL %s valid got %b want %b", tag, if_id_valid, e.valid); end
        assert (halted === e.halted) else begin errors++; $error("FAIL %s halted got %b want %b", tag, halted, e.halted); end
    endtask

    initial begin
        for (int i = 0; i < `IMEMORY_SIZE; i++) imem[i] = iw(i);
        drive(0, 0, 0, 0, 0); expect_st(0, NOP, 0, 0, 0); tick("reset");
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            expect_st(i + 1, iw(i), i, 1, 0); tick("freerun");
        end
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect_st(5, iw(4), 4, 1, 0); tick("stall");
        end
        drive(1, 1, 1, 0, 0); expect_st(5, NOP, 5, 0, 0); tick("flush_stall");
        drive(1, 0, 1, 0, 0); expect_st(6, NOP, 5, 0, 0); tick("flush");
        drive(1, 0, 0, 0, 0);
        if (HD) begin
            expect_st(6, HLT, 6, 1, 1); tick("halt_enter");
            expect_st(6, NOP, 6, 0, 1); tick("halt_hold");
            drive(1, 1, 0, 0, 0); expect_st(6, NOP, 6, 0, 1); tick("halt_stall");
            drive(1, 0, 0, 1, 2); expect_st(2, NOP, 6, 0, 0); tick("halt_branch");
        end else begin
            expect_st(7, HLT, 6, 1, 0); tick("halt_ordinary");
            expect_st(8, iw(7), 7, 1, 0); tick("after_halt_word");
            drive(1, 0, 0, 1, 2); expect_st(2, NOP, 8, 0, 0); tick("branch");
        end
        drive(1, 0, 0, 0, 0); expect_st(3, iw(2), 2, 1, 0); tick("post_branch");
        drive(1, 1, 0, 1, 8); expect_st(8, NOP, 3, 0, 0); tick("branch_stall");
        drive(1, 0, 0, 0, 0); expect_st(9, iw(8), 8, 1, 0); tick("branch_target_fetch");
        drive(1, 0, 0, 1, 200); expect_st(0, NOP, 9, 0, 0); tick("branch_oob");
        drive(1, 0, 0, 0, 0); expect_st(1, iw(0), 0, 1, 0); tick("oob_fetch");
        drive(1, 0, 0, 1, 15); expect_st(15, NOP, 1, 0, 0); tick("branch_15");
        drive(1, 0, 0, 0, 0); expect_st(0, iw(15), 15, 1, 0); tick("wrap");
        expect_st(1, iw(0), 0, 1, 0); tick("wrap_next");
        drive(1, 0, 0, 1, 6); expect_st(6, NOP, 1, 0, 0); tick("branch_6");
        drive(1, 0, 0, 0, 0);
        if (HD) begin
            expect_st(6, HLT, 6, 1, 1); tick("halt_again");
        end else begin
            expect_st(7, HLT, 6, 1, 0); tick("halt_word_again");
        end
        drive(0, 1, 1, 1, 9); expect_st(0, NOP, 0, 0, 0); tick("reset_override");
        drive(1, 0, 0, 0, 0); expect_st(1, iw(0), 0, 1, 0); tick("post_reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 0, PC value loaded on reset.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-004 SHALL provide port: stall  input  1  hold PC and IF/ID contents.
REQ-005 SHALL provide port: flush  input  1  squash IF/ID to NOP.
REQ-006 SHALL provide port: branch_taken  input  1  redirect fetch.
REQ-007 SHALL provide port: branch_target  input  `ADDR_WIDTH  redirect address.
REQ-008 SHALL provide port: instruction  input  `INST_WIDTH  word returned combinationally by instruction memory for pc.
REQ-009 SHALL provide port: pc  output  `ADDR_WIDTH  fetch address to instruction memory.
REQ-010 SHALL provide port: if_id_instruction  output  `INST_WIDTH  registered instruction to decode.
REQ-011 SHALL provide port: if_id_pc  output  `ADDR_WIDTH  address of if_id_instruction.
REQ-012 SHALL provide port: if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 SHALL provide port: halted  output  1  fetch stopped on halt.

Function
REQ-014 pc SHALL be a register; instruction is sampled in the same cycle pc is presented (zero-latency memory), IF/ID updated at the following edge.
REQ-015 Per-edge priority SHALL be: reset > branch_taken > flush > stall > normal fetch.
REQ-016 Normal fetch: pc <= pc+1; IF/ID <= {instruction, pc, valid=1}.
REQ-017 pc increment SHALL wrap: pc == `IMEMORY_SIZE-1 -> next pc 0.
REQ-018 branch_taken: pc <= branch_target; IF/ID <= {`NOP_INST, pc, valid=0}; stall ignored that cycle.
REQ-019 branch_target >= `IMEMORY_SIZE SHALL load pc with 0.
REQ-020 flush without branch_taken: IF/ID <= NOP, valid=0; pc advances unless stall=1, in which case pc holds.
REQ-021 stall alone: pc and all IF/ID outputs SHALL hold unchanged.
REQ-022 State machine SHALL have states RUN and HALT; halted = (state == HALT).
REQ-023 In HALT, pc SHALL hold and IF/ID SHALL load NOP with valid=0 each cycle.

Reset
REQ-024 reset low at an edge SHALL set pc=RESET_PC, if_id_instruction=`NOP_INST, if_id_pc=0, if_id_valid=0, state=RUN, halted=0.
REQ-025 Reset asserted mid-operation (any state, concurrent stall/branch/flush) SHALL override all other inputs.

Configuration
REQ-026 Macro FETCH_HALT_DETECT_EN SHALL enable halt detection.
REQ-027 With macro: in RUN, a normal-fetch edge capturing instruction == `HALT_INST SHALL load it into IF/ID (valid=1), hold pc at the halt address, and enter HALT; branch_taken in HALT SHALL redirect and return to RUN (older in-flight branch wins).
REQ-028 Without macro: HALT unreachable, halted tied 0, `HALT_INST fetched as an ordinary instruction.

Structure
REQ-029 `ADDR_WIDTH, `INST_WIDTH, `IMEMORY_SIZE, `NOP_INST, `HALT_INST SHALL live in the shared defines file; state encodings local.
REQ-030 IF/ID register SHALL be a sub-module if_id_register (load, squash, hold controls); PC logic and FSM remain in fetch_unit.

Verification
REQ-031 Reset then 4 free-run cycles, memory {A,B,C,D} -> if_id_pc 0,1,2,3, if_id_valid 1 from first post-reset edge, pc=4.
REQ-032 `IMEMORY_SIZE=16, run from pc=15 -> next pc 0, if_id_pc 15 then 0.
REQ-033 branch_taken=1, target=8, stall=1 same cycle -> pc=8, if_id_valid=0; next edge if_id_pc=8.
REQ-034 stall=1 for 3 cycles at pc=5 -> pc and IF/ID unchanged; flush+stall -> pc 5, if_id_valid 0.
REQ-035 FETCH_HALT_DETECT_EN, `HALT_INST at address 6 -> if_id_pc 6 valid 1, halted=1, pc stays 6, then valid 0; branch_taken target 2 -> halted 0, pc 2.
REQ-036 reset low while HALT with branch_taken=1 -> pc=RESET_PC, halted 0, if_id_valid 0.
